// File: rtl/speech256_top.sv
// rtl/speech256_top.sv - allophone player: one-entry code queue, pulse/noise source, one-pole filter, PWM out.
module speech256_top (
  input  logic        clk,
  input  logic        rst_an,
  input  logic [5:0]  data_in,
  input  logic        data_stb,
  output logic        ldq,
  output logic        pwm_out,
  output logic [15:0] sample_out,
  output logic        sample_stb
);

  typedef enum logic {IDLE, PLAY} state_t;

  state_t      state;
  logic [7:0]  cnt;
  logic        q_full;
  logic [5:0]  q_code;
  logic [5:0]  code;
  logic [10:0] idx;
  logic [6:0]  ph;
  logic [15:0] lfsr;

  logic        boundary, pause, voiced, last, load, lfsr_fb;
  logic [4:0]  frames;
  logic [10:0] last_idx;
  logic [15:0] amp, x, y_sat;
  logic [6:0]  period;
  logic signed [16:0] x17, y17, diff, sum;

  // The edge that raises sample_stb is the sample boundary.
  assign boundary = (cnt == 8'd254);
  assign pause    = (code < 6'd5);
  assign voiced   = code[0];

  always_comb begin
    case (code)
      6'd0:    frames = 5'd1;
      6'd1:    frames = 5'd3;
      6'd2:    frames = 5'd5;
      6'd3:    frames = 5'd10;
      6'd4:    frames = 5'd20;
      default: frames = 5'd4 + {2'b00, code[2:0]};
    endcase
  end

  assign last_idx = {frames, 6'b000000} - 11'd1;
  assign last     = (idx == last_idx);
  assign load     = q_full && ((state == IDLE) || last);
  assign amp      = 16'h1000 + {3'b000, code[5:1], 8'h00};
  assign period   = 7'd64 + {2'b00, code[5:3], 2'b00};
  assign lfsr_fb  = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];

  always_comb begin
    x = '0;
    if (state == PLAY && !pause) begin
      if (voiced) x = (ph < {1'b0, period[6:1]}) ? amp : -amp;
      else        x = lfsr[0] ? amp : -amp;
    end
  end

  assign x17  = {x[15], x};
  assign y17  = {sample_out[15], sample_out};
  assign diff = x17 - y17;
  assign sum  = y17 + (diff >>> 2);
  assign y_sat = (sum[16] != sum[15]) ? (sum[16] ? 16'h8000 : 16'h7fff) : sum[15:0];

  assign ldq        = ~q_full;
  assign sample_stb = (cnt == 8'hff);
  assign pwm_out    = ~rst_an & (cnt < (sample_out[15:8] ^ 8'h80));

  always_ff @(posedge clk or posedge rst_an) begin
    if (rst_an) begin
      cnt        <= '0;
      q_full     <= 1'b0;
      q_code     <= '0;
      code       <= '0;
      idx        <= '0;
      ph         <= '0;
      lfsr       <= 16'hACE1;
      sample_out <= '0;
      state      <= IDLE;
    end else begin
      cnt <= cnt + 8'd1;
      if (data_stb && !q_full) begin
        q_full <= 1'b1;
        q_code <= data_in;
      end
      if (boundary) begin
        sample_out <= y_sat;
        if (state == PLAY) begin
          if (!pause && !voiced) lfsr <= {lfsr_fb, lfsr[15:1]};
          ph  <= (ph == period - 7'd1) ? 7'd0 : ph + 7'd1;
          idx <= idx + 11'd1;
        end
        // Transfer wins over a same-cycle strobe: the strobe only lands when q_full was 0.
        if (load) begin
          code   <= q_code;
          q_full <= 1'b0;
          idx    <= '0;
          ph     <= '0;
          state  <= PLAY;
        end else if (state == PLAY && last) begin
          state <= IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_speech256_top.sv
// tb/tb_speech256_top.sv - random-stimulus bench for speech256_top against a per-sample behavioural model.
module tb_speech256_top;

  logic        clk = 1'b0;
  logic        rst_an = 1'b1;
  logic [5:0]  data_in = '0;
  logic        data_stb = 1'b0;
  logic        ldq, pwm_out, sample_stb;
  logic [15:0] sample_out;

  int passed = 0;
  int total  = 0;

  int m_cnt, m_y, m_lfsr, m_play, m_code, m_n;
  int m_pend[$];

  speech256_top dut (
    .clk(clk), .rst_an(rst_an), .data_in(data_in), .data_stb(data_stb),
    .ldq(ldq), .pwm_out(pwm_out), .sample_out(sample_out), .sample_stb(sample_stb)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic int dur_samples(input int c);
    int fr;
    case (c)
      0: fr = 1;
      1: fr = 3;
      2: fr = 5;
      3: fr = 10;
      4: fr = 20;
      default: fr = 4 + (c % 8);
    endcase
    return fr * 64;
  endfunction

  function automatic int source_val();
    int a, p;
    if (m_play == 0 || m_code < 5) return 0;
    a = 4096 + 256 * (m_code / 2);
    if (m_code % 2 == 1) begin
      p = 64 + 4 * (m_code / 8);
      return ((m_n % p) < p / 2) ? a : -a;
    end
    return (m_lfsr % 2 == 1) ? a : -a;
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_y = 0; m_lfsr = 16'hACE1; m_play = 0; m_code = 0; m_n = 0;
    m_pend.delete();
  endtask

  task automatic model_edge(input bit stb, input int d);
    bit acc;
    int x, fb;
    acc = stb && (m_pend.size() == 0);
    if (m_cnt == 254) begin
      x = source_val();
      if (m_play != 0 && m_code >= 5 && m_code % 2 == 0) begin
        fb = (m_lfsr ^ (m_lfsr >> 2) ^ (m_lfsr >> 3) ^ (m_lfsr >> 5)) & 1;
        m_lfsr = (m_lfsr >> 1) | (fb << 15);
      end
      m_y = m_y + ((x - m_y) >>> 2);
      if (m_y > 32767) m_y = 32767;
      if (m_y < -32768) m_y = -32768;
      if (m_play != 0) begin
        m_n++;
        if (m_n == dur_samples(m_code)) m_play = 0;
      end
      if (m_play == 0 && m_pend.size() != 0) begin
        m_code = m_pend.pop_front();
        m_n = 0;
        m_play = 1;
      end
    end
    if (acc) m_pend.push_back(d);
    m_cnt = (m_cnt + 1) % 256;
  endtask

  task automatic step(input bit stb, input int d);
    data_stb = stb;
    data_in  = 6'(d);
    @(posedge clk);
    model_edge(stb, d);
    @(negedge clk);
    data_stb = 1'b0;
    check("sample_stb", int'(sample_stb), int'(m_cnt == 255));
    check("ldq", int'(ldq), int'(m_pend.size() == 0));
    check("sample_out", int'($signed(sample_out)), m_y);
    check("pwm_out", int'(pwm_out), int'(m_cnt < (((m_y >> 8) & 255) ^ 128)));
  endtask

  task automatic run(input int cycles, input bit noise);
    for (int i = 0; i < cycles; i++) begin
      if (noise && $urandom_range(0, 799) == 0) step(1'b1, $urandom_range(0, 63));
      else step(1'b0, 0);
    end
  endtask

  task automatic do_reset();
    #2 rst_an = 1'b1;
    #1;
    check("rst_ldq", int'(ldq), 1);
    check("rst_pwm", int'(pwm_out), 0);
    check("rst_sample", int'(sample_out), 0);
    check("rst_stb", int'(sample_stb), 0);
    @(posedge clk);
    @(negedge clk);
    rst_an = 1'b0;
    model_reset();
  endtask

  task automatic wait_ldq(input int budget);
    int n = 0;
    while (m_pend.size() != 0 && n < budget) begin
      step(1'b0, 0);
      n++;
    end
    check("ldq_timeout", int'(m_pend.size() == 0), 1);
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    @(negedge clk);
    do_reset();

    // idle: silent output, 128/256 PWM duty, periodic strobe
    run(3 * 256, 1'b0);

    // shortest pause, then back to idle
    step(1'b1, 6'h00);
    run(66 * 256, 1'b0);

    // voiced 0x07 with an ignored strobe while the queue is full, then reset mid-allophone
    do_reset();
    step(1'b1, 6'h07);
    step(1'b1, $urandom_range(0, 63));
    run(30 * 256 + $urandom_range(0, 255), 1'b0);
    step(1'b1, 6'h2D);
    run($urandom_range(10, 600), 1'b0);
    do_reset();

    // unvoiced 0x06, LFSR from its reset seed
    step(1'b1, 6'h06);
    run(30 * 256, 1'b0);
    do_reset();

    // pause followed by a random code queued via the ldq handshake: no gap sample
    step(1'b1, 6'h00);
    wait_ldq(300);
    step(1'b1, $urandom_range(5, 63));
    run(68 * 256, 1'b1);
    do_reset();

    // random codes strobed at random phases, cut short by reset
    for (int r = 0; r < 2; r++) begin
      run($urandom_range(0, 255), 1'b0);
      step(1'b1, $urandom_range(0, 63));
      run(15 * 256 + $urandom_range(0, 255), 1'b1);
      do_reset();
    end
    run(300, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
